// File: rtl/pipelined_adder.sv
// Pipelined ripple-slice adder/subtractor with valid/ready flow control.
// Each stage resolves one SLICE-bit slice of the sum; the final stage
// register drives the result outputs directly.
module pipelined_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             count,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / SLICE;
    localparam int unsigned LAST   = STAGES - 1;
    localparam int unsigned SW     = SLICE + 1;

    // Per-stage state: operands (effective B), partial sum, slice carry, mode, valid
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic             sub_q   [STAGES];
    logic             sub_d   [STAGES];
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_sum;
    logic             op_c;
    logic             op_sub;
    logic             op_v;
    logic [SLICE:0]   slice_res;
    logic             advance_c;

    // Whole pipe moves together whenever the output slot is free or being drained
    assign advance_c = !valid_q[LAST] || out_ready;
    // Reset always empties the pipe, so upstream is never held off during it
    assign in_ready  = advance_c || sys_rst;

    // Next-state of every stage: stage s resolves slice s from the previous stage's carry
    always_comb begin
        op_a      = '0;
        op_b      = '0;
        op_sum    = '0;
        op_c      = 1'b0;
        op_sub    = 1'b0;
        op_v      = 1'b0;
        slice_res = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (s == 0) begin
                op_a   = in_a;
                op_b   = in_sub ? ~in_b : in_b;
                op_c   = in_sub | in_cin;
                op_sum = '0;
                op_sub = in_sub;
                op_v   = in_valid;
            end else begin
                op_a   = a_q[s-1];
                op_b   = b_q[s-1];
                op_c   = carry_q[s-1];
                op_sum = sum_q[s-1];
                op_sub = sub_q[s-1];
                op_v   = valid_q[s-1];
            end
            slice_res = SW'(op_a[s*SLICE +: SLICE]) + SW'(op_b[s*SLICE +: SLICE]) + SW'(op_c);
            a_d[s]     = op_a;
            b_d[s]     = op_b;
            sub_d[s]   = op_sub;
            valid_d[s] = op_v;
            sum_d[s]   = op_sum;
            sum_d[s][s*SLICE +: SLICE] = slice_res[SLICE-1:0];
            carry_d[s] = slice_res[SLICE];
        end
    end

    // Stage registers: reset clears everything, stall holds, advance shifts
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                a_q[s]     <= '0;
                b_q[s]     <= '0;
                sum_q[s]   <= '0;
                carry_q[s] <= 1'b0;
                sub_q[s]   <= 1'b0;
            end
        end else if (advance_c) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_q[s] <= valid_d[s];
                // Stage 0 data only loads on a real handshake; bubbles keep stale data
                if ((s != 0) || in_valid) begin
                    a_q[s]     <= a_d[s];
                    b_q[s]     <= b_d[s];
                    sum_q[s]   <= sum_d[s];
                    carry_q[s] <= carry_d[s];
                    sub_q[s]   <= sub_d[s];
                end
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign count     = carry_q[LAST];
    // Signed overflow: operands agree in sign but the result does not
    assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                       (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=16, SLICE=4).
module tb_pipelined_adder;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        count;
    logic        ovf;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic        vs [8];
    logic [15:0] es [8];
    logic        ec [8];
    logic        eo [8];

    pipelined_adder #(.WIDTH(16), .SLICE(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .count     (count),
        .ovf       (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
    endtask

    task automatic init_vectors();
        va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 0; vs[0] = 0; es[0] = 16'h5555; ec[0] = 0; eo[0] = 0;
        va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vc[1] = 0; vs[1] = 0; es[1] = 16'hFFFE; ec[1] = 1; eo[1] = 0;
        va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 0; vs[2] = 0; es[2] = 16'h0000; ec[2] = 1; eo[2] = 1;
        va[3] = 16'h0F0F; vb[3] = 16'h00F1; vc[3] = 1; vs[3] = 0; es[3] = 16'h1001; ec[3] = 0; eo[3] = 0;
        va[4] = 16'h1000; vb[4] = 16'h0001; vc[4] = 0; vs[4] = 1; es[4] = 16'h0FFF; ec[4] = 1; eo[4] = 0;
        va[5] = 16'h0000; vb[5] = 16'h0000; vc[5] = 0; vs[5] = 1; es[5] = 16'h0000; ec[5] = 1; eo[5] = 0;
        va[6] = 16'h7FFF; vb[6] = 16'hFFFF; vc[6] = 0; vs[6] = 1; es[6] = 16'h8000; ec[6] = 0; eo[6] = 1;
        va[7] = 16'hABCD; vb[7] = 16'h1111; vc[7] = 1; vs[7] = 0; es[7] = 16'hBCDF; ec[7] = 0; eo[7] = 0;
    endtask

    // Push one operand set into an empty pipe and wait (bounded) for its result
    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic sub, output logic [15:0] rs, output logic rc,
                           output logic ro, output int lat);
        out_ready = 1'b1;
        drive(1'b1, a, b, cin, sub);
        step();
        lat = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        rs = sum;
        rc = count;
        ro = ovf;
        step();
    endtask

    task automatic test_reset();
        sys_rst   = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        step();
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (sum !== 16'h0000) $display("FAIL reset_sum: got %h expected 0000", sum); else n_pass++;
        n_total++; if (count !== 1'b0) $display("FAIL reset_count: got %b expected 0", count); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        sys_rst  = 1'b0;
        in_valid = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_single_add();
        out_ready = 1'b1;
        drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            n_total++; if (out_valid !== 1'b0) $display("FAIL single_early_valid edge%0d: got %b expected 0", e, out_valid); else n_pass++;
            step();
        end
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid_edge4: got %b expected 1", out_valid); else n_pass++;
        n_total++; if ({sum, count, ovf} !== {16'h0100, 1'b0, 1'b0})
            $display("FAIL single_result: got sum=%h c=%b o=%b expected sum=0100 c=0 o=0", sum, count, ovf); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_consumed: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_carry();
        logic [15:0] rs; logic rc; logic ro; int lat;
        run_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, rs, rc, ro, lat);
        n_total++; if (lat !== 4) $display("FAIL carry_all_latency: got %0d expected 4", lat); else n_pass++;
        n_total++; if ({rs, rc, ro} !== {16'h0000, 1'b1, 1'b0})
            $display("FAIL carry_all: got sum=%h c=%b o=%b expected sum=0000 c=1 o=0", rs, rc, ro); else n_pass++;
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        n_total++; if (lat !== 4) $display("FAIL carry_ovf_latency: got %0d expected 4", lat); else n_pass++;
        n_total++; if ({rs, rc, ro} !== {16'h8000, 1'b0, 1'b1})
            $display("FAIL carry_ovf: got sum=%h c=%b o=%b expected sum=8000 c=0 o=1", rs, rc, ro); else n_pass++;
    endtask

    task automatic test_subtract();
        logic [15:0] rs; logic rc; logic ro; int lat;
        run_one(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, ro, lat);
        n_total++; if ({rs, rc, ro} !== {16'hFFFE, 1'b0, 1'b0})
            $display("FAIL sub_borrow: got sum=%h c=%b o=%b expected sum=fffe c=0 o=0", rs, rc, ro); else n_pass++;
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat);
        n_total++; if ({rs, rc, ro} !== {16'h7FFF, 1'b1, 1'b1})
            $display("FAIL sub_ovf: got sum=%h c=%b o=%b expected sum=7fff c=1 o=1", rs, rc, ro); else n_pass++;
        // carry-in must be ignored when subtracting
        run_one(16'h0005, 16'h0007, 1'b1, 1'b1, rs, rc, ro, lat);
        n_total++; if ({rs, rc, ro} !== {16'hFFFE, 1'b0, 1'b0})
            $display("FAIL sub_cin_ignored: got sum=%h c=%b o=%b expected sum=fffe c=0 o=0", rs, rc, ro); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int rx = 0;
        int first = -1;
        int last = -1;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive(1'b1, va[c], vb[c], vc[c], vs[c]);
            else in_valid = 1'b0;
            step();
            if (out_valid) begin
                if (rx < 8) begin
                    n_total++; if ({sum, count, ovf} !== {es[rx], ec[rx], eo[rx]})
                        $display("FAIL b2b_result%0d: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                                 rx, sum, count, ovf, es[rx], ec[rx], eo[rx]); else n_pass++;
                end
                if (first < 0) first = c;
                last = c;
                rx++;
            end
        end
        n_total++; if (rx !== 8) $display("FAIL b2b_count: got %0d expected 8", rx); else n_pass++;
        n_total++; if (first !== 3) $display("FAIL b2b_first_cycle: got %0d expected 3", first); else n_pass++;
        n_total++; if (last !== 10) $display("FAIL b2b_last_cycle: got %0d expected 10", last); else n_pass++;
    endtask

    task automatic test_backpressure();
        int tx = 0;
        int rx = 0;
        int extra = 0;
        for (int c = 0; c < 40 && rx < 8; c++) begin
            out_ready = (c >= 7);
            if (tx < 8) drive(1'b1, va[tx], vb[tx], vc[tx], vs[tx]);
            else in_valid = 1'b0;
            #1;
            if (c >= 4 && c < 7) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready); else n_pass++;
                n_total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid c%0d: got %b expected 1", c, out_valid); else n_pass++;
                n_total++; if ({sum, count, ovf} !== {es[0], ec[0], eo[0]})
                    $display("FAIL bp_stable c%0d: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                             c, sum, count, ovf, es[0], ec[0], eo[0]); else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_total++; if ({sum, count, ovf} !== {es[rx], ec[rx], eo[rx]})
                    $display("FAIL bp_result%0d: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                             rx, sum, count, ovf, es[rx], ec[rx], eo[rx]); else n_pass++;
                rx++;
            end
            if (in_valid && in_ready) tx++;
            step();
        end
        n_total++; if (rx !== 8) $display("FAIL bp_rx_count: got %0d expected 8", rx); else n_pass++;
        n_total++; if (tx !== 8) $display("FAIL bp_tx_count: got %0d expected 8", tx); else n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) extra++;
            step();
        end
        n_total++; if (extra !== 0) $display("FAIL bp_duplicates: got %0d expected 0", extra); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        logic [15:0] rs; logic rc; logic ro; int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, va[i + 1], vb[i + 1], vc[i + 1], vs[i + 1]);
            step();
        end
        sys_rst = 1'b1;
        drive(1'b1, va[6], vb[6], vc[6], vs[6]);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else n_pass++;
        step();
        sys_rst  = 1'b0;
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if ({sum, count, ovf} !== {16'h0000, 1'b0, 1'b0})
            $display("FAIL midrst_outputs: got sum=%h c=%b o=%b expected sum=0000 c=0 o=0", sum, count, ovf); else n_pass++;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL midrst_ghost_results: got %0d expected 0", seen); else n_pass++;
        run_one(va[7], vb[7], vc[7], vs[7], rs, rc, ro, lat);
        n_total++; if ({rs, rc, ro, lat} !== {es[7], ec[7], eo[7], 32'd4})
            $display("FAIL midrst_recover: got sum=%h c=%b o=%b lat=%0d expected sum=%h c=%b o=%b lat=4",
                     rs, rc, ro, lat, es[7], ec[7], eo[7]); else n_pass++;
    endtask

    initial begin
        sys_rst   = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        init_vectors();
        test_reset();
        test_single_add();
        test_carry();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter SLICE, default 4: bits resolved per pipeline stage; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 SHALL derive STAGES = WIDTH/SLICE (default 4): pipeline depth.
REQ-004 SHALL have port sys_clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port sys_rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1: operand set presented.
REQ-007 SHALL have port in_ready  output  1: block can accept an operand set this cycle.
REQ-008 SHALL have port in_a  input  WIDTH: operand A.
REQ-009 SHALL have port in_b  input  WIDTH: operand B.
REQ-010 SHALL have port in_cin  input  1: carry-in; ignored in subtract mode.
REQ-011 SHALL have port in_sub  input  1: mode; 0 = add (A+B+cin), 1 = subtract (A-B).
REQ-012 SHALL have port out_valid  output  1: result present.
REQ-013 SHALL have port out_ready  input  1: downstream accepts the result.
REQ-014 SHALL have port sum  output  WIDTH: result, modulo 2^WIDTH.
REQ-015 SHALL have port count  output  1: carry-out of bit WIDTH-1; in subtract mode 1 = no borrow.
REQ-016 SHALL have port ovf  output  1: two's-complement signed overflow.

Function
REQ-017 SHALL compute add as A + B + cin and subtract as A + ~B + 1, evaluated at WIDTH+1 bits; count = bit WIDTH; sum = bits WIDTH-1:0.
REQ-018 SHALL set ovf = 1 when the MSBs of A and the effective B (B or ~B) are equal and differ from the sum MSB; otherwise 0.
REQ-019 SHALL split the carry chain into STAGES registered stages; stage k resolves slice k (bits k*SLICE .. k*SLICE+SLICE-1) using the carry registered from stage k-1.
REQ-020 SHALL carry unresolved upper operand slices, effective B, mode and the per-stage valid bit alongside each partial result.
REQ-021 SHALL make a handshake occur on a rising edge where in_valid and in_ready are both 1; data SHALL be captured only on such edges.
REQ-022 SHALL define advance = !out_valid | out_ready; in_ready SHALL equal advance combinationally.
REQ-023 SHALL shift all stages one position on every edge where advance = 1; bubbles (invalid stages) are not collapsed.
REQ-024 SHALL hold every stage unchanged on every edge where advance = 0, keeping sum, count and ovf stable while out_valid = 1.
REQ-025 SHALL load stage 1 valid with in_valid on an advance edge; in_valid = 0 inserts a bubble.
REQ-026 SHALL present a result with out_valid = 1 after exactly STAGES rising edges counted from and including its handshake edge, given no stall.
REQ-027 SHALL sustain one result per cycle when in_valid and out_ready are held 1.
REQ-028 SHALL allow a full pipeline with out_ready = 1 to accept a new input on the same edge the oldest result is consumed.
REQ-029 SHALL deliver results in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-030 SHALL treat sum, count and ovf as don't-care when out_valid = 0.

Reset
REQ-031 SHALL clear all stage valid bits on an edge where sys_rst = 1, discarding in-flight operations, so out_valid = 0 after that edge.
REQ-032 SHALL reset sum, count and ovf to 0.
REQ-033 SHALL drive in_ready = 1 while sys_rst = 1 and after reset, and SHALL NOT capture inputs on a reset edge.
REQ-034 SHALL give sys_rst priority over every handshake on the same edge.

Verification (WIDTH=16, SLICE=4)
REQ-035 Single add: A=0x00FF, B=0x0001, cin=0, accepted on edge 1 -> out_valid=1 after edge 4, sum=0x0100, count=0, ovf=0.
REQ-036 Carry across all slices: A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, count=1, ovf=0; A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, ovf=1.
REQ-037 Subtract: A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, count=0; A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, ovf=1, count=1.
REQ-038 Back-to-back stream of 8 random operand sets with out_ready=1 -> 8 correct results on 8 consecutive cycles, in order.
REQ-039 Backpressure: pipeline full, out_ready=0 for 3 cycles -> in_ready=0, outputs stable; out_ready=1 -> drain and accept resume with no loss.
REQ-040 Reset mid-stream: sys_rst=1 for one edge with 3 operations in flight -> out_valid=0, sum=0, count=0, ovf=0 next cycle; none of the 3 results ever appear.
